// File: rtl/rr_sel4.sv
// rtl/rr_sel4.sv - four-channel round-robin arbiter driving the 4:1 mux select
//
// Rotates grants fairly across four request lines and holds each grant for
// at most BURST accepted beats, or until the granted channel drops its request.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   req    in   4  per-channel beat available
//   ready  in   1  consumer accepts the current beat
//   s      out  2  registered select index for the downstream mux
//   gnt    out  4  registered one-hot grant (1<<s while busy, else 0)
//   valid  out  1  beat present: busy && req[s]
//   busy   out  1  registered grant-held flag
module rr_sel4 #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] s_n;
  logic [3:0] gnt_n;

  logic       beat;
  logic       release_now;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;

  // Returns {found, index}: first requester scanning start, start+1, ...
  // (mod 4). The loop runs backwards so the lowest offset is written last.
  function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int j = 3; j >= 0; j--) begin
      idx = start + 2'(j);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign beat        = (state == GRANT) && req[s] && ready;
  assign release_now = (state == GRANT) && (!req[s] || (beat && (cnt == LAST_BEAT)));
  assign pick_idle   = arb(req, ptr);
  // On release the search restarts just past the channel being released.
  assign pick_rel    = arb(req, s + 2'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
      s     <= 2'd0;
      gnt   <= 4'd0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      s     <= s_n;
      gnt   <= gnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    s_n     = s;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_n = GRANT;
          s_n     = pick_idle[1:0];
          gnt_n   = 4'b0001 << pick_idle[1:0];
          cnt_n   = 4'd0;
        end else begin
          gnt_n   = 4'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n = s + 2'd1;
          cnt_n = 4'd0;
          if (pick_rel[2]) begin
            s_n   = pick_rel[1:0];
            gnt_n = 4'b0001 << pick_rel[1:0];
          end else begin
            // s keeps its last value so the mux input stays put while idle.
            state_n = IDLE;
            gnt_n   = 4'd0;
          end
        end else if (beat) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'd0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state == GRANT);
    valid = (state == GRANT) && req[s];
  end

endmodule

// File: doc/rr_sel4.md
# rr_sel4

Four-channel round-robin arbiter that sits directly upstream of the team's 4:1 data mux (`mux2s`). It watches four request lines and produces the mux's 2-bit select `s`, plus a one-hot grant and a beat-valid to the consumer. Grants rotate fairly and are held for a bounded burst of beats, so one channel cannot starve the others.

## Interface
- `BURST`, default 4: maximum beats per grant; legal range 1..15.
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-channel request; `req[i]`=1 means channel i has a beat available.
- `ready`  in  1  downstream accepts the current beat this cycle.
- `s`  out  2  select index; drives `mux2s.s` directly; registered.
- `gnt`  out  4  one-hot grant, equal to `1<<s` while granted, else 0; registered.
- `valid`  out  1  beat present: `busy && req[s]`; combinational from `req`.
- `busy`  out  1  grant currently held; registered.

## Operation
- Internal state:
  - `ptr` (2 bits): search start index.
  - `cnt` (4 bits): beats transferred in the current grant.
  - State machine with two states: IDLE (`busy`=0) and GRANT (`busy`=1).
- Beat transfer: occurs on a rising edge where `valid && ready` = 1. `ready` is ignored when `valid`=0.
- Arbitration function: starting at `ptr`, scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). Pick the first i with `req[i]`=1.
- IDLE:
  - If `req`≠0: go to GRANT with `s` = arbitration result, `gnt` = `1<<s`, `cnt` = 0.
  - Else stay in IDLE; `s` holds its last value and `gnt` = 0.
- GRANT, release condition evaluated each edge: `req[s]`=0, or a beat transfers with `cnt+1 == BURST`.
  - No release: `cnt` increments on each beat and holds otherwise; `s` and `gnt` hold.
  - Release: `ptr` ← `s+1` (mod 4); `cnt` ← 0. Re-arbitrate in the same edge using current `req` and the new `ptr`.
    - Any requester found: stay in GRANT with the new `s`/`gnt`. This may be the same channel if it is the only requester.
    - None found: go to IDLE, `gnt` ← 0.
- Fairness: with all four requesting continuously, grants rotate 0→1→2→3→0, each lasting exactly `BURST` beats when `ready`=1 throughout.
- Arithmetic: `ptr` and `s` wrap modulo 4. `cnt` never exceeds `BURST-1` at an edge, so the 4-bit width is sufficient.
- Reset (asynchronous, any time, including mid-burst):
  - `s`=0, `gnt`=0, `busy`=0, `ptr`=0, `cnt`=0; therefore `valid`=0.
  - The first grant after reset searches from channel 0.

## Timing
- Request to grant: 1 cycle. `req` seen at edge k gives `gnt`/`s`/`busy` valid after edge k.
- `valid` follows `req[s]` combinationally within the cycle while `busy`=1. There is no registered delay on request drop.
- Back-to-back grants have zero dead cycles when another request is pending at the release edge.
- Changes to `s` take effect only at clock edges, so the downstream mux output is stable for a full cycle.
- `ready` low stalls the burst: `cnt`, `s` and `gnt` hold and nothing is dropped.
- A request dropping mid-burst releases at that edge, regardless of `cnt`.

## Test plan
- Reset: assert `rst` mid-burst (`gnt`=0100, `cnt`=2) → immediately `gnt`=0, `s`=0, `busy`=0, `valid`=0. After release with `req`=1000 → one cycle later `s`=3, `gnt`=1000.
- Full rotation: `BURST`=4, `req`=1111, `ready`=1 for 20 cycles → `s` sequence 0×4, 1×4, 2×4, 3×4, 0×4 with no gaps; `valid`=1 throughout.
- Stall: `req`=0001, `ready` toggling 1,0,0,1,1,1 → grant to 0 ends after the 4th accepted beat. Then `s`=0 is re-granted, because it is the sole requester, with `cnt`=0.
- Early drop: channel 2 granted, `req[2]` falls after 1 beat with `req`=1001 pending, `ptr`=3 → next `s`=3; following grant goes to 0.
- Idle return: single request `req`=0010 for 2 beats then `req`=0 → `busy`=0, `gnt`=0, `s` holds 1, `valid`=0, `ptr`=2.
- `BURST`=1, `req`=0101, `ready`=1 → grants alternate 0,2,0,2 every cycle.
